shape_iter: RTL
===============

# shape_iter

Sequencer that walks the shape table from id 0 to `count-1`. It drives the `id`/`trigger` side of `shape_read` and waits for each record fetch to finish. It then presents the fetched shape fields downstream on a valid/ready stream, one beat per shape. It sits between the frame/scene controller (which issues `start`) and the per-shape raster/compose stage.

## Interface
- `NUMW`, 12: width of shape id and count.
- `CORDW`, 10: coordinate width.
- `DATAW`, 12: record word width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a pass; sampled only in IDLE.
- `count` in NUMW: number of shapes in the pass; sampled with `start`.
- `rd_id` out NUMW: id driven to `shape_read`.
- `rd_trigger` out 1: one-cycle fetch request to `shape_read`.
- `rd_busy` in 1: `shape_read` busy.
- `rd_ty`, `rd_size`, `rd_rotate` in DATAW: fetched fields.
- `rd_x`, `rd_y` in CORDW: fetched fields.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_id` out NUMW: id of the beat.
- `out_ty`, `out_size`, `out_rotate` out DATAW: registered copies of the fetched fields.
- `out_x`, `out_y` out CORDW: registered copies of the fetched fields.
- `out_last` out 1: beat is id `count-1`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when the pass ends.

## Operation
- States: IDLE, TRIG, WAIT, OUT, FIN.
- IDLE:
  - `start` with `count`==0 goes to FIN.
  - `start` with `count`>0 latches `count`, sets `id`=0, goes to TRIG.
  - `start` in any other state is ignored.
- TRIG: `rd_trigger`=1 (combinational, TRIG only); go to WAIT.
- WAIT:
  - While `rd_busy`=1, hold.
  - On `rd_busy`=0, capture all `rd_*` fields and `rd_id` into the `out_*` registers, then go to OUT.
- OUT:
  - `out_valid`=1.
  - On `out_valid && out_ready`: if `id`==`count-1` go to FIN, else `id`+=1 and go to TRIG.
- FIN: `done`=1 for exactly one cycle; go to IDLE.
- `rd_id` = current `id` register; it is stable from TRIG through the end of WAIT.
- `out_last` = (`out_id` == `count_latched-1`). NUMW-bit compare; no wrap, because `id` never exceeds `count-1`.
- `out_*` fields are held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - state IDLE, `id`=0.
  - `rd_trigger`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
  - All `out_*` data = 0.
- `start` at cycle S → TRIG at S+1 → `rd_busy` high at S+2..S+9 (8-word record).
- The WAIT cycle that sees `rd_busy`=0 is S+10, and the capture happens at that cycle's edge. First `out_valid` is at S+11.
- Per-shape period with `out_ready` held high: 11 cycles (TRIG + 8 busy + capture + OUT).
- Pass of N shapes with `out_ready`=1: `done` at S+1+11N. For N=0, `done` at S+1.
- WAIT relies on `rd_busy` rising the cycle after `rd_trigger`. The reader guarantees this, so no extra arm cycle is needed.
- `out_ready` asserted outside OUT has no effect.
- Reset mid-pass: returns to IDLE next edge, `out_valid` drops, no `done` pulse. `shape_read` shares `rst`.

## Configuration
- `SHAPE_ITER_SKIP_EMPTY_EN` defined:
  - In WAIT, if the captured `rd_ty`==0, skip OUT. Advance `id` to TRIG, or go to FIN if `id`==`count-1`.
  - Empty shapes produce no beat. If the last shape is empty, no beat carries `out_last`; `done` still pulses.
- Not defined: every id 0..`count-1` produces exactly one beat regardless of type.

## Test plan
- `count`=3, `out_ready`=1, records ty=1,2,3, x=10,20,30 → three beats:
  - `out_id` 0,1,2 with matching fields;
  - `out_last` only on id 2;
  - `done` at S+34.
- `count`=0, `start` → `done` at S+1, `rd_trigger` never asserted.
- `count`=2, `out_ready` low for 5 cycles on beat 0 → `out_*` stable, no `rd_trigger` until the handshake, then beat 1 follows 11 cycles later.
- `start` pulsed again mid-pass → ignored, id sequence unchanged.
- `rst` during WAIT of id 1 → next cycle IDLE, `out_valid`=0, `busy`=0, no `done`; a new `start` restarts at id 0.
- With `SHAPE_ITER_SKIP_EMPTY_EN`, `count`=3, ty=1,0,2 → beats for ids 0 and 2 only, `out_last` on id 2, `done` pulses. Without the macro → 3 beats.

Source files
------------

// File: rtl/shape_iter.sv
// Shape-table sequencer: fetches records 0..count-1 through shape_read and
// streams each one downstream. Optional macro SHAPE_ITER_SKIP_EMPTY_EN drops ty==0 records.
module shape_iter #(
    parameter int NUMW  = 12,
    parameter int CORDW = 10,
    parameter int DATAW = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUMW-1:0]  count,
    output logic [NUMW-1:0]  rd_id,
    output logic             rd_trigger,
    input  logic             rd_busy,
    input  logic [DATAW-1:0] rd_ty,
    input  logic [DATAW-1:0] rd_size,
    input  logic [DATAW-1:0] rd_rotate,
    input  logic [CORDW-1:0] rd_x,
    input  logic [CORDW-1:0] rd_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUMW-1:0]  out_id,
    output logic [DATAW-1:0] out_ty,
    output logic [DATAW-1:0] out_size,
    output logic [DATAW-1:0] out_rotate,
    output logic [CORDW-1:0] out_x,
    output logic [CORDW-1:0] out_y,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, OUT, FIN} state_t;

    state_t          state, state_next;
    logic [NUMW-1:0] id;
    logic [NUMW-1:0] count_l;
    logic            at_last;
    logic            fetch_done;
    logic            empty;
    logic            advance;

    assign at_last    = (id == count_l - NUMW'(1));
    assign fetch_done = (state == WAIT) && !rd_busy;

`ifdef SHAPE_ITER_SKIP_EMPTY_EN
    assign empty = (rd_ty == '0);
`else
    assign empty = 1'b0;
`endif

    // id moves on either after a handshake or after dropping an empty record
    assign advance = ((state == OUT) && out_ready) || (fetch_done && empty);

    assign rd_id    = id;
    assign out_last = (out_id == count_l - NUMW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (count == '0) ? FIN : TRIG;
            end
            TRIG: state_next = WAIT;
            WAIT: begin
                if (!rd_busy) begin
                    if (empty)
                        state_next = at_last ? FIN : TRIG;
                    else
                        state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_next = at_last ? FIN : TRIG;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_trigger = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            TRIG:    rd_trigger = 1'b1;
            OUT:     out_valid  = 1'b1;
            FIN:     done       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id         <= '0;
            count_l    <= '0;
            out_id     <= '0;
            out_ty     <= '0;
            out_size   <= '0;
            out_rotate <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            if ((state == IDLE) && start && (count != '0)) begin
                count_l <= count;
                id      <= '0;
            end
            // rd_* are only meaningful once the reader drops busy
            if (fetch_done) begin
                out_id     <= id;
                out_ty     <= rd_ty;
                out_size   <= rd_size;
                out_rotate <= rd_rotate;
                out_x      <= rd_x;
                out_y      <= rd_y;
            end
            if (advance && !at_last)
                id <= id + NUMW'(1);
        end
    end

endmodule
